// File: rtl/fp_sub_seq.sv
// fp_sub_seq: sequential FP32 subtractor, result = a - b (simplified format:
// no special values, truncation, 8-bit modulo exponent).
// Ports: clk/rst (async, active-high); in_valid/in_ready + a/b operand handshake;
// out_valid/out_ready + result output handshake; busy high outside IDLE.
// Latency: d'+n+3 edges (non-zero result) or d'+2 (exact zero) after accept.
// Backpressure: result and out_valid are held in DONE until out_ready.
module fp_sub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  exp_q, exp_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] mx_q, mx_d;
    logic [23:0] my_q, my_d;
    logic        sx_q, sx_d;
    logic        sy_q, sy_d;
    logic [24:0] sum_q, sum_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;

    // Operand decode at the accept edge; b is negated by flipping its sign bit.
    logic [7:0]  ea, eb, ediff;
    logic        a_is_x;
    logic [31:0] bneg;
    logic [24:0] sum_w;
    logic        sign_w;

    assign bneg   = {~b[31], b[30:0]};
    assign ea     = a[30:23];
    assign eb     = bneg[30:23];
    assign a_is_x = (ea >= eb);
    assign ediff  = a_is_x ? (ea - eb) : (eb - ea);

    // Mantissa combine: magnitudes are compared so the difference never wraps.
    always_comb begin
        sum_w  = '0;
        sign_w = sx_q;
        if (sx_q == sy_q) begin
            sum_w  = {1'b0, mx_q} + {1'b0, my_q};
            sign_w = sx_q;
        end else if (mx_q >= my_q) begin
            sum_w  = {1'b0, mx_q} - {1'b0, my_q};
            sign_w = sx_q;
        end else begin
            sum_w  = {1'b0, my_q} - {1'b0, mx_q};
            sign_w = sy_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        mx_d     = mx_q;
        my_d     = my_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        sum_d    = sum_q;
        sign_d   = sign_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (a_is_x) begin
                        sx_d  = a[31];
                        mx_d  = {1'b1, a[22:0]};
                        sy_d  = bneg[31];
                        my_d  = {1'b1, bneg[22:0]};
                        exp_d = ea;
                    end else begin
                        sx_d  = bneg[31];
                        mx_d  = {1'b1, bneg[22:0]};
                        sy_d  = a[31];
                        my_d  = {1'b1, a[22:0]};
                        exp_d = eb;
                    end
                    // Beyond 25 shifts mY is already all zeros.
                    cnt_d   = (ediff > 8'd25) ? 5'd25 : ediff[4:0];
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q != 5'd0) begin
                    my_d  = my_q >> 1;
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (sum_w == 25'd0) begin
                    result_d = 32'h0000_0000;
                    state_d  = DONE;
                end else begin
                    sum_d   = sum_w;
                    sign_d  = sign_w;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (sum_q[24]) begin
                    sum_d = sum_q >> 1;
                    exp_d = exp_q + 8'd1;
                end else if (sum_q[23]) begin
                    result_d = {sign_q, exp_q, sum_q[22:0]};
                    state_d  = DONE;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 8'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            cnt_q    <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            sum_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            sum_q    <= sum_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed bench for fp_sub_seq: hand-computed results and latencies,
// output hold under back-pressure, and mid-operation reset.
module tb_fp_sub_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks;
    int failures;

    fp_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Accept one operand pair, then count edges until out_valid (sampled #1
    // after each edge). Operand inputs are scrambled after accept.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, output int lat);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input int el);
        int lat;
        issue(av, bv, lat);
        check({tag, "_lat"}, lat, el);
        check({tag, "_res"}, result, er);
        handshake(tag);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sub3m1",   32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4);
        run_op("carry",    32'h3FC0_0000, 32'hBFC0_0000, 32'h4040_0000, 4);
        run_op("cancel",   32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6);
        run_op("negres",   32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 4);
        run_op("zero",     32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 2);
        run_op("gap24",    32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 27);
        run_op("gap30",    32'h4E80_0000, 32'h3F80_0000, 32'h4E80_0000, 28);

        // Back-pressure: result held with out_ready low for 5 cycles.
        issue(32'h4040_0000, 32'h3F80_0000, lat);
        check("bp_lat", lat, 4);
        held = result;
        check("bp_res", held, 32'h4000_0000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_stable", result, 32'h4000_0000);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        handshake("bp");

        // Reset while in ALIGN (gap 24 keeps it there for many cycles).
        @(negedge clk);
        a = 32'h4B80_0000;
        b = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_result", result, 32'h0);
        // Operands offered during reset must be ignored.
        a = 32'h4040_0000;
        b = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ignored_busy", {31'd0, busy}, 32'd0);

        run_op("post_rst", 32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
